// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch controller with a one-entry skid buffer.
//
// Issues one outstanding request at a time to an instruction memory and
// presents the returned words to decode, together with their PC.
// If decode stalls while a response is landing, that response is parked
// in a skid buffer. Branch redirects flush the output. A redirect that
// arrives while a request is still outstanding waits in DRAIN until the
// stale response has been retired.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   branch_sel, branch_inp redirect pulse and target from execute
//   stall                  decode cannot accept the held instruction
//   imem_req, imem_addr    memory request valid and fetch address
//   imem_ready, imem_rdata memory response strobe and instruction word
//   pc_present, inst       held instruction and its PC
//   inst_valid             pc_present/inst hold a real instruction
//
// state | meaning
// IDLE  | first cycle after reset, no request issued
// RUN   | request outstanding, responses flow to the output
// SKID  | output stalled and skid buffer full, no request issued
// DRAIN | redirect pending, waiting to discard the outstanding response
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_sel,
    input  logic [31:0] branch_inp,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_present,
    output logic [31:0] inst,
    output logic        inst_valid
);

    typedef enum logic [1:0] {IDLE, RUN, SKID, DRAIN} state_t;

    state_t      state;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic        skid_valid;
    logic [31:0] redirect;
    logic [31:0] target;

    assign target = branch_inp & ~32'h3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            pc_present <= RESET_PC;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            skid_inst  <= 32'h0;
            skid_pc    <= 32'h0;
            skid_valid <= 1'b0;
            redirect   <= 32'h0;
        end else begin
            // A redirect always flushes the output and the skid buffer; the
            // state-specific handling below only decides where fetch resumes.
            if (branch_sel) begin
                inst_valid <= 1'b0;
                inst       <= NOP_INST;
                skid_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state    <= RUN;
                    imem_req <= 1'b1;
                    if (branch_sel)
                        imem_addr <= target;
                end

                RUN: begin
                    if (branch_sel) begin
                        if (imem_ready) begin
                            imem_addr <= target;
                        end else begin
                            // Address must stay put for the outstanding request.
                            redirect <= target;
                            state    <= DRAIN;
                        end
                    end else if (imem_ready) begin
                        imem_addr <= imem_addr + 32'd4;
                        if (!inst_valid || !stall) begin
                            inst       <= imem_rdata;
                            pc_present <= imem_addr;
                            inst_valid <= 1'b1;
                        end else begin
                            skid_inst  <= imem_rdata;
                            skid_pc    <= imem_addr;
                            skid_valid <= 1'b1;
                            state      <= SKID;
                            imem_req   <= 1'b0;
                        end
                    end else if (!stall) begin
                        inst_valid <= 1'b0;
                        inst       <= NOP_INST;
                    end
                end

                SKID: begin
                    if (branch_sel) begin
                        imem_addr <= target;
                        state     <= RUN;
                        imem_req  <= 1'b1;
                    end else if (!stall) begin
                        inst       <= skid_inst;
                        pc_present <= skid_pc;
                        inst_valid <= skid_valid;
                        skid_valid <= 1'b0;
                        state      <= RUN;
                        imem_req   <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (branch_sel)
                        redirect <= target;
                    if (imem_ready) begin
                        // The newest target wins if it arrives with the response.
                        imem_addr <= branch_sel ? target : redirect;
                        state     <= RUN;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl. Stimulus pushes expected {pc, inst}
// pairs; a negedge monitor pops one each time decode accepts an output.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_sel;
    logic [31:0] branch_inp;
    logic        stall;
    logic        imem_ready;
    logic        imem_req,  req2;
    logic [31:0] imem_addr, addr2;
    logic [31:0] imem_rdata, rdata2;
    logic [31:0] pc_present, pc2;
    logic [31:0] inst, inst2;
    logic        inst_valid, valid2;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    // Memory model: word at address A is A + 0x100.
    assign imem_rdata = imem_addr + 32'h100;
    assign rdata2     = addr2 + 32'h100;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .branch_sel(branch_sel), .branch_inp(branch_inp),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc_present(pc_present), .inst(inst), .inst_valid(inst_valid)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .branch_sel(branch_sel), .branch_inp(branch_inp),
        .stall(stall), .imem_req(req2), .imem_addr(addr2),
        .imem_ready(imem_ready), .imem_rdata(rdata2),
        .pc_present(pc2), .inst(inst2), .inst_valid(valid2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_q.push_back({pc, pc + 32'h100});
    endtask

    task automatic start_test(input logic rdy);
        reset      = 1'b1;
        imem_ready = rdy;
        stall      = 1'b0;
        branch_sel = 1'b0;
        branch_inp = 32'h0;
        tick();
        tick();
    endtask

    task automatic end_test();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: an output is consumed when it is valid and decode is not stalled.
    always @(negedge clk) begin
        if (!reset && inst_valid && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got pc=%h inst=%h expected none", pc_present, inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({pc_present, inst} !== e) begin
                    errors++;
                    $display("FAIL output: got pc=%h inst=%h expected pc=%h inst=%h",
                             pc_present, inst, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait stream, stall at PC=8, wrap instance alongside.
        start_test(1'b1);
        check("rst_req",   {31'h0, imem_req}, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_pc",    pc_present, 32'h0);
        check("rst_inst",  inst, 32'h13);
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        check("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
        check("wrap_rst_pc",   pc2, 32'hFFFF_FFFC);
        push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
        reset = 1'b0;
        #1;
        check("idle_req", {31'h0, imem_req}, 32'h0);
        tick();
        check("first_req",  {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        check("wrap_addr2", addr2, 32'h0);
        check("wrap_pc",    pc2, 32'hFFFF_FFFC);
        check("wrap_inst",  inst2, 32'h0000_00FC);
        tick();
        check("wrap_pc_next",  pc2, 32'h0);
        check("wrap_addr_next", addr2, 32'h4);
        tick();
        stall = 1'b1;
        tick();
        check("skid_req",   {31'h0, imem_req}, 32'h0);
        check("skid_pc",    pc_present, 32'h8);
        check("skid_inst",  inst, 32'h108);
        check("skid_valid", {31'h0, inst_valid}, 32'h1);
        tick();
        tick();
        check("skid_hold_pc", pc_present, 32'h8);
        check("skid_hold_req", {31'h0, imem_req}, 32'h0);
        stall = 1'b0;
        tick();
        check("skid_release_addr", imem_addr, 32'h10);
        check("skid_release_req", {31'h0, imem_req}, 32'h1);
        tick();
        end_test();

        // Two wait states, bubble, then reset mid-request.
        start_test(1'b0);
        push(32'h0);
        reset = 1'b0;
        tick();
        tick();
        check("wait_addr1", imem_addr, 32'h0);
        tick();
        check("wait_addr2", imem_addr, 32'h0);
        check("wait_req",   {31'h0, imem_req}, 32'h1);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        check("bubble_valid", {31'h0, inst_valid}, 32'h0);
        check("bubble_inst",  inst, 32'h13);
        check("bubble_addr",  imem_addr, 32'h4);
        reset = 1'b1;
        #1;
        check("midrst_req",   {31'h0, imem_req}, 32'h0);
        check("midrst_addr",  imem_addr, 32'h0);
        check("midrst_pc",    pc_present, 32'h0);
        check("midrst_inst",  inst, 32'h13);
        check("midrst_valid", {31'h0, inst_valid}, 32'h0);
        check("midrst_queue", exp_q.size(), 0);

        // Branch while a request to 0x20 is waiting -> DRAIN.
        start_test(1'b1);
        for (int i = 0; i < 8; i++) push(32'(i * 4));
        push(32'h40);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("pre_branch_addr", imem_addr, 32'h20);
        imem_ready = 1'b0;
        tick();
        branch_sel = 1'b1;
        branch_inp = 32'h40;
        tick();
        branch_sel = 1'b0;
        check("drain_addr",  imem_addr, 32'h20);
        check("drain_req",   {31'h0, imem_req}, 32'h1);
        check("drain_valid", {31'h0, inst_valid}, 32'h0);
        imem_ready = 1'b1;
        tick();
        check("post_drain_addr",  imem_addr, 32'h40);
        check("post_drain_valid", {31'h0, inst_valid}, 32'h0);
        tick();
        end_test();

        // Branch with stall and ready together, unaligned target.
        start_test(1'b1);
        push(32'h0);
        push(32'h28);
        reset = 1'b0;
        tick();
        tick();
        tick();
        stall      = 1'b1;
        branch_sel = 1'b1;
        branch_inp = 32'h2B;
        tick();
        stall      = 1'b0;
        branch_sel = 1'b0;
        check("flush_addr",  imem_addr, 32'h28);
        check("flush_valid", {31'h0, inst_valid}, 32'h0);
        check("flush_inst",  inst, 32'h13);
        tick();
        end_test();

        // Second branch during DRAIN overrides, used directly with ready.
        start_test(1'b0);
        push(32'h80);
        reset = 1'b0;
        tick();
        branch_sel = 1'b1;
        branch_inp = 32'h40;
        tick();
        check("drain2_addr", imem_addr, 32'h0);
        branch_inp = 32'h81;
        imem_ready = 1'b1;
        tick();
        branch_sel = 1'b0;
        check("override_addr", imem_addr, 32'h80);
        tick();
        end_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
